// File: rtl/ldl_pkg.sv
// ---------------------------------------------------------------------------
// ldl_pkg
// Shared types and helpers for the ldl rotate primitives.
//   dir_e         : rotate direction, ROT_LEFT (toward MSB) / ROT_RIGHT
//   stage_amount  : rotate distance contributed by one log stage
// ---------------------------------------------------------------------------
package ldl_pkg;

  typedef enum logic {
    ROT_LEFT  = 1'b0,
    ROT_RIGHT = 1'b1
  } dir_e;

  // Stage k of the log rotator moves by 2^k, folded into the word width so
  // non-power-of-two widths still sum to (step mod width) across stages.
  function automatic int stage_amount(input int k, input int width);
    return (1 << k) % width;
  endfunction

endpackage

// File: rtl/ldl_rotate_comb.sv
// ---------------------------------------------------------------------------
// ldl_rotate_comb
// Purely combinational logarithmic circular rotator.
//   WIDTH : data width (>= 2)
//   dir   : ROT_LEFT or ROT_RIGHT
//   step  : rotate amount, taken modulo WIDTH
//   x     : input word
//   y     : rotated word
// ---------------------------------------------------------------------------
module ldl_rotate_comb
  import ldl_pkg::*;
#(
  parameter  int WIDTH = 8,
  localparam int SW    = $clog2(WIDTH)
) (
  input  dir_e             dir,
  input  logic [SW-1:0]    step,
  input  logic [WIDTH-1:0] x,
  output logic [WIDTH-1:0] y
);

  logic [WIDTH-1:0] cur;
  logic [WIDTH-1:0] nxt;
  int               amt;

  // Each enabled stage rotates the running word by its fixed distance.
  // Rotations compose additively modulo WIDTH, so the chain realises
  // (step mod WIDTH) in either direction.
  always_comb begin
    cur = x;
    nxt = x;
    amt = 0;
    for (int k = 0; k < SW; k++) begin
      amt = stage_amount(k, WIDTH);
      nxt = cur;
      if (step[k]) begin
        for (int i = 0; i < WIDTH; i++) begin
          if (dir == ROT_LEFT) begin
            nxt[(i + amt) % WIDTH] = cur[i];
          end else begin
            nxt[i] = cur[(i + amt) % WIDTH];
          end
        end
      end
      cur = nxt;
    end
    y = cur;
  end

endmodule

// File: rtl/ldl_shift_ring.sv
// ---------------------------------------------------------------------------
// ldl_shift_ring
// Registered barrel rotator: one word per cycle, one cycle of latency.
//   clk       : clock, rising edge
//   rst_n     : synchronous active-low reset
//   in_valid  : qualifies dir/step/x
//   dir       : 0 rotate left (toward MSB), 1 rotate right
//   step      : rotate amount, applied modulo WIDTH
//   x         : input word
//   out_valid : in_valid delayed one cycle
//   y         : registered rotated word, held when no new input
// ---------------------------------------------------------------------------
module ldl_shift_ring
  import ldl_pkg::*;
#(
  parameter  int WIDTH = 8,
  localparam int SW    = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic             dir,
  input  logic [SW-1:0]    step,
  input  logic [WIDTH-1:0] x,
  output logic             out_valid,
  output logic [WIDTH-1:0] y
);

  // A one-bit word has no meaningful rotation and a zero-width step port.
  if (WIDTH < 2) begin : g_width_check
    $error("ldl_shift_ring: WIDTH must be at least 2");
  end

  logic [WIDTH-1:0] rotated;

  ldl_rotate_comb #(
    .WIDTH(WIDTH)
  ) u_rotate (
    .dir (dir_e'(dir)),
    .step(step),
    .x   (x),
    .y   (rotated)
  );

  // Reset wins over a word arriving on the same edge; otherwise y only
  // loads on accepted words and holds between them.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      y         <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        y <= rotated;
      end
    end
  end

endmodule

// File: tb/tb_ldl_shift_ring.sv
// ---------------------------------------------------------------------------
// tb_ldl_shift_ring
// Drives an 8-bit and a 6-bit ldl_shift_ring in lockstep and checks them
// against a modulo-arithmetic rotate model delayed by one cycle.
// ---------------------------------------------------------------------------
module tb_ldl_shift_ring;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       dir = 1'b0;
  logic [2:0] step8 = '0;
  logic [2:0] step6 = '0;
  logic [7:0] x8 = '0;
  logic [5:0] x6 = '0;
  logic [7:0] y8;
  logic [5:0] y6;
  logic       ov8;
  logic       ov6;

  int tests = 0;
  int fails = 0;

  logic [7:0] expY8 = '0;
  logic [5:0] expY6 = '0;
  logic       expV  = 1'b0;

  logic [7:0] leftTab  [8] = '{8'hA5, 8'h4B, 8'h96, 8'h2D, 8'h5A, 8'hB4, 8'h69, 8'hD2};
  logic [7:0] rightTab [8] = '{8'hA5, 8'hD2, 8'h69, 8'hB4, 8'h5A, 8'h2D, 8'h96, 8'h4B};

  always #5 clk = ~clk;

  ldl_shift_ring #(.WIDTH(8)) dut8 (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .dir      (dir),
    .step     (step8),
    .x        (x8),
    .out_valid(ov8),
    .y        (y8)
  );

  ldl_shift_ring #(.WIDTH(6)) dut6 (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .dir      (dir),
    .step     (step6),
    .x        (x6),
    .out_valid(ov6),
    .y        (y6)
  );

  // Rotating left by s is multiplying by 2^s modulo (2^w - 1), done here as
  // low part plus carried-out high part; right by s is left by w - s.
  function automatic longint rotRef(input int w, input bit d, input int stepVal,
                                    input longint xv);
    longint s;
    longint p;
    longint m;
    s = stepVal % w;
    if (d) s = (w - s) % w;
    m = longint'(1) << w;
    p = xv * (longint'(1) << s);
    return (p % m) + (p / m);
  endfunction

  // Drive one cycle of inputs, advance the model, and step past the edge.
  task automatic applyStimulus(input bit r, input bit iv, input bit d,
                               input logic [2:0] s8, input logic [7:0] xa,
                               input logic [2:0] s6, input logic [5:0] xb);
    rst_n    = r;
    in_valid = iv;
    dir      = d;
    step8    = s8;
    x8       = xa;
    step6    = s6;
    x6       = xb;
    if (!r) begin
      expY8 = '0;
      expY6 = '0;
      expV  = 1'b0;
    end else begin
      expV = iv;
      if (iv) begin
        expY8 = 8'(rotRef(8, d, int'(s8), longint'(xa)));
        expY6 = 6'(rotRef(6, d, int'(s6), longint'(xb)));
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic checkValue(input string tag, input logic [31:0] obs,
                            input logic [31:0] expd);
    tests++;
    assert (obs === expd)
    else begin
      fails++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, expd);
    end
  endtask

  // Compare both instances against the reference model.
  task automatic checkOutput(input string tag);
    checkValue({tag, " y8"}, 32'(y8), 32'(expY8));
    checkValue({tag, " ov8"}, 32'(ov8), 32'(expV));
    checkValue({tag, " y6"}, 32'(y6), 32'(expY6));
    checkValue({tag, " ov6"}, 32'(ov6), 32'(expV));
  endtask

  initial begin
    // Reset state, with in_valid high to show reset priority.
    applyStimulus(1'b0, 1'b1, 1'b0, 3'd1, 8'hFF, 3'd1, 6'h3F);
    checkOutput("reset");
    checkValue("reset y8 zero", 32'(y8), 32'h0);
    checkValue("reset ov8 low", 32'(ov8), 32'h0);

    // Left sweep of 0xA5.
    for (int s = 0; s < 8; s++) begin
      applyStimulus(1'b1, 1'b1, 1'b0, 3'(s), 8'hA5, 3'(s), 6'h25);
      checkOutput("left sweep");
      checkValue($sformatf("left step %0d", s), 32'(y8), 32'(leftTab[s]));
    end

    // Right sweep, also checked against the left table at (8 - s) mod 8.
    for (int s = 0; s < 8; s++) begin
      applyStimulus(1'b1, 1'b1, 1'b1, 3'(s), 8'hA5, 3'(s), 6'h25);
      checkOutput("right sweep");
      checkValue($sformatf("right step %0d", s), 32'(y8), 32'(rightTab[s]));
      checkValue($sformatf("right %0d eq left %0d", s, (8 - s) % 8), 32'(y8),
                 32'(leftTab[(8 - s) % 8]));
    end

    // Back-to-back words.
    applyStimulus(1'b1, 1'b1, 1'b0, 3'd7, 8'h01, 3'd0, 6'h00);
    checkValue("pipe0 y", 32'(y8), 32'h80);
    checkValue("pipe0 ov", 32'(ov8), 32'h1);
    applyStimulus(1'b1, 1'b1, 1'b1, 3'd7, 8'h80, 3'd0, 6'h00);
    checkValue("pipe1 y", 32'(y8), 32'h01);
    checkValue("pipe1 ov", 32'(ov8), 32'h1);
    applyStimulus(1'b1, 1'b1, 1'b1, 3'd3, 8'hFF, 3'd0, 6'h00);
    checkValue("pipe2 y", 32'(y8), 32'hFF);
    checkValue("pipe2 ov", 32'(ov8), 32'h1);
    checkOutput("pipe2");

    // Valid gating: y holds, out_valid drops.
    applyStimulus(1'b1, 1'b0, 1'b0, 3'd1, 8'h12, 3'd1, 6'h12);
    checkValue("gate hold y", 32'(y8), 32'hFF);
    checkValue("gate ov", 32'(ov8), 32'h0);
    checkOutput("gate");

    // Reset together with in_valid.
    applyStimulus(1'b0, 1'b1, 1'b0, 3'd1, 8'h5A, 3'd1, 6'h15);
    checkValue("rst prio y", 32'(y8), 32'h0);
    checkValue("rst prio ov", 32'(ov8), 32'h0);

    // First edge after reset release accepts a word normally.
    applyStimulus(1'b1, 1'b1, 1'b0, 3'd2, 8'h81, 3'd2, 6'h21);
    checkValue("post rst y", 32'(y8), 32'h06);
    checkValue("post rst ov", 32'(ov8), 32'h1);
    checkOutput("post rst");

    // Non-power-of-two width, x = 0b000011.
    applyStimulus(1'b1, 1'b1, 1'b0, 3'd0, 8'h00, 3'd7, 6'b000011);
    checkValue("w6 left 7", 32'(y6), 32'b000110);
    applyStimulus(1'b1, 1'b1, 1'b1, 3'd0, 8'h00, 3'd6, 6'b000011);
    checkValue("w6 right 6", 32'(y6), 32'b000011);
    applyStimulus(1'b1, 1'b1, 1'b1, 3'd0, 8'h00, 3'd1, 6'b000011);
    checkValue("w6 right 1", 32'(y6), 32'b100001);
    checkOutput("w6");

    // Random traffic including occasional resets and idle cycles.
    for (int n = 0; n < 10000; n++) begin
      applyStimulus(($urandom_range(0, 99) >= 3), ($urandom_range(0, 3) != 0),
                    1'($urandom), 3'($urandom), 8'($urandom),
                    3'($urandom), 6'($urandom));
      checkOutput("random");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/ldl_shift_ring.md
# ldl_shift_ring

Registered barrel rotator: each accepted input word is rotated circularly by a variable step count, in a selectable direction, and presented one clock later. It is a library primitive for datapaths that need a single-cycle circular rotate, such as lane alignment, round-robin masks and CRC/crypto helpers. No bits are lost: bits shifted out of one end re-enter at the other.

## Interface
- `WIDTH`, default 8: data width in bits. Legal values are ≥ 2; values that are not a power of two are legal.
- `SW`, derived as $clog2(WIDTH): width of the step port. It is a localparam and must not be overridden.
- `clk` in 1: the single clock. All state updates on the rising edge.
- `rst_n` in 1: synchronous, active-low reset, sampled on the rising edge of `clk`.
- `in_valid` in 1: qualifies `dir`, `step` and `x`.
- `dir` in 1: rotate direction. 0 rotates left (toward the MSB); 1 rotates right (toward the LSB).
- `step` in SW: rotate amount, 0 to 2^SW−1.
- `x` in WIDTH: input word.
- `out_valid` out 1: `y` holds a new result.
- `y` out WIDTH: rotated word, registered.

## Operation
- Left rotate: `y[(i+s) mod WIDTH] = x[i]`. Right rotate: `y[i] = x[(i+s) mod WIDTH]`.
- The effective step is `s = step mod WIDTH`.
  - For a power-of-two WIDTH, every step value is in range.
  - For other widths, a step ≥ WIDTH wraps (for example WIDTH=6, step=7 behaves as step=1).
- `step = 0` passes `x` through unchanged in either direction.
- Left by s equals right by (WIDTH − s) mod WIDTH. Both directions must agree on this identity.
- Rotation is purely bitwise. There is no sign handling and no fill value.
- The rotate network is logarithmic, with SW stages. Stage k rotates by (2^k mod WIDTH) when `step[k]` is 1. Direction is applied per stage.

## Timing
- Latency is exactly 1 cycle. Inputs sampled at edge N appear on `y`/`out_valid` after edge N.
- Throughput is one word per cycle. There is no backpressure and no stall.
- `out_valid` is `in_valid` delayed by one cycle.
- `y` updates only on cycles where `in_valid` = 1. Otherwise it holds its last value.
- Reset (`rst_n` = 0 at an edge): `y` = 0 and `out_valid` = 0.
  - Reset takes priority over `in_valid` arriving on the same edge.
  - A word accepted on the edge before reset is visible for one cycle and is then cleared.
- The cycle after `rst_n` deasserts behaves normally. An `in_valid` sampled on the first edge with `rst_n` = 1 produces `out_valid` one cycle later.
- `dir` and `step` may change on every accepted word. There is no settling requirement.

## Structure
- A shared package `ldl_pkg` holds a `dir_e` enum: `ROT_LEFT` = 0, `ROT_RIGHT` = 1.
- Sub-module `ldl_rotate_comb`: a purely combinational log-stage rotator with parameter WIDTH and ports dir/step/x/y.
- The top level instantiates `ldl_rotate_comb` and adds the output/valid registers and reset.
- Elaboration check: fail if WIDTH < 2.

## Test plan
All vectors use WIDTH=8 and x=0xA5 with `in_valid` = 1; results are checked one cycle later.
- Left sweep, dir=0, step 0..7: y = A5, 4B, 96, 2D, 5A, B4, 69, D2.
- Right sweep, dir=1, step 0..7: y = A5, D2, 69, B4, 5A, 2D, 96, 4B.
  - Check left(s) == right(8−s) for every s.
- Back-to-back pipeline, one word per cycle: x=0x01 dir=0 step=7, then x=0x80 dir=1 step=7, then x=0xFF dir=1 step=3.
  - Outputs on consecutive cycles: 0x80, 0x01, 0xFF, each with `out_valid` = 1.
- Valid gating and reset: drop `in_valid` after a word and check that y holds and `out_valid` = 0.
  - Then assert `rst_n` = 0 together with `in_valid` = 1: the next cycle gives y = 0 and `out_valid` = 0.
- Non-power-of-two WIDTH=6, x=0b000011:
  - dir=0 step=7 → 0b000110.
  - dir=1 step=6 → 0b000011.
  - dir=1 step=1 → 0b100001.
- Random: 10k cycles of random dir/step/x/in_valid/rst_n, compared against a modulo-arithmetic reference with a one-cycle delay.
